// File: rtl/div_pkg.sv
// Shared types and sign helpers for the sequential restoring divider.
// Helpers work on MAX_W-bit values; callers sign-extend narrower operands first.
package div_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] value,
                                                input logic             neg);
    logic [MAX_W-1:0] res;
    if (neg) begin
      res = ~value + 32'd1;
    end else begin
      res = value;
    end
    return res;
  endfunction

  // value must already be sign-extended to MAX_W when is_signed is set
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] value,
                                               input logic             is_signed);
    return cond_neg(value, is_signed & value[MAX_W-1]);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// subtract the divisor if it fits, and report the resulting quotient bit.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dvd_bit,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;
  logic           unused_s;

  // The partial remainder is always below the divisor, so its top bit never carries information in.
  assign unused_s = p[WIDTH];

  // Compare/subtract at WIDTH+1 bits so divisors above 2^(WIDTH-1) do not lose the carry.
  always_comb begin
    shifted_s = {p[WIDTH-1:0], dvd_bit};
    diff_s    = shifted_s - {1'b0, divisor};
    if (shifted_s >= {1'b0, divisor}) begin
      p_next = diff_s;
      q_bit  = 1'b1;
    end else begin
      p_next = shifted_s;
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/div_seq_param.sv
// Parametrised sequential restoring divider with signed/unsigned mode,
// start/busy/done handshake and divide-by-zero reporting; one quotient bit per clock.
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  state_t           state_r;
  logic [WIDTH:0]   p_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CNT_W-1:0] count_r;
  logic             sign_q_r;
  logic             sign_r_r;
  logic             zero_r;

  logic [WIDTH:0]   p_next_s;
  logic             q_bit_s;
  logic [MAX_W-1:0] a_ext_s;
  logic [MAX_W-1:0] b_ext_s;
  logic [MAX_W-1:0] a_abs_s;
  logic [MAX_W-1:0] b_abs_s;
  logic [MAX_W-1:0] q_fix_s;
  logic [MAX_W-1:0] r_fix_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic             unused_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p       (p_r),
    .divisor (dvs_r),
    .dvd_bit (dvd_r[WIDTH-1]),
    .p_next  (p_next_s),
    .q_bit   (q_bit_s)
  );

  // Operand magnitudes on the way in and sign restoration on the way out.
  always_comb begin
    if (is_signed) begin
      a_ext_s = MAX_W'($signed(a));
      b_ext_s = MAX_W'($signed(b));
    end else begin
      a_ext_s = MAX_W'(a);
      b_ext_s = MAX_W'(b);
    end
    a_abs_s = abs_val(a_ext_s, is_signed);
    b_abs_s = abs_val(b_ext_s, is_signed);
    a_neg_s = is_signed & a[WIDTH-1];
    b_neg_s = is_signed & b[WIDTH-1];
    q_fix_s = cond_neg(MAX_W'(dvd_r), sign_q_r);
    r_fix_s = cond_neg(MAX_W'(p_r[WIDTH-1:0]), sign_r_r);
  end

  // Bits above WIDTH of the helper results and the remainder guard bit are intentionally dropped.
  assign unused_s = ^{a_abs_s, b_abs_s, q_fix_s, r_fix_s, p_r[WIDTH]};

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      p_r       <= {(WIDTH+1){1'b0}};
      dvd_r     <= {WIDTH{1'b0}};
      dvs_r     <= {WIDTH{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      sign_q_r  <= 1'b0;
      sign_r_r  <= 1'b0;
      zero_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= {WIDTH{1'b0}};
      remainder <= {WIDTH{1'b0}};
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            sign_q_r <= a_neg_s ^ b_neg_s;
            sign_r_r <= a_neg_s;
            count_r  <= CNT_W'(WIDTH);
            p_r      <= {(WIDTH+1){1'b0}};
            dvs_r    <= b_abs_s[WIDTH-1:0];
            busy     <= 1'b1;
            if (b == {WIDTH{1'b0}}) begin
              // keep the raw dividend so it can be returned as the remainder
              zero_r  <= 1'b1;
              dvd_r   <= a;
              state_r <= FIX;
            end else begin
              zero_r  <= 1'b0;
              dvd_r   <= a_abs_s[WIDTH-1:0];
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          p_r     <= p_next_s;
          dvd_r   <= {dvd_r[WIDTH-2:0], q_bit_s};
          count_r <= count_r - CNT_W'(1);
          if (count_r == CNT_W'(1)) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          div_zero <= zero_r;
          state_r  <= IDLE;
          if (zero_r) begin
            quotient  <= {WIDTH{1'b1}};
            remainder <= dvd_r;
          end else begin
            quotient  <= q_fix_s[WIDTH-1:0];
            remainder <= r_fix_s[WIDTH-1:0];
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Directed self-checking bench for div_seq_param at WIDTH 8, 16 and 32.
module tb_div_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        st8, st16, st32, sgn;
  logic [31:0] a_v, b_v;

  logic        busy8, done8, dz8;
  logic [7:0]  q8, r8;
  logic        busy16, done16, dz16;
  logic [15:0] q16, r16;
  logic        busy32, done32, dz32;
  logic [31:0] q32, r32;

  int          sel_w = 16;
  logic        busy_m, done_m, dz_m;
  logic [31:0] q_m, r_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_seq_param #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst(rst), .start(st8), .is_signed(sgn), .a(a_v[7:0]), .b(b_v[7:0]),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_zero(dz8));
  div_seq_param #(.WIDTH(16)) u_d16 (
    .clk(clk), .rst(rst), .start(st16), .is_signed(sgn), .a(a_v[15:0]), .b(b_v[15:0]),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_zero(dz16));
  div_seq_param #(.WIDTH(32)) u_d32 (
    .clk(clk), .rst(rst), .start(st32), .is_signed(sgn), .a(a_v), .b(b_v),
    .busy(busy32), .done(done32), .quotient(q32), .remainder(r32), .div_zero(dz32));

  // Route the outputs of the instance under test onto one set of observation signals.
  always_comb begin
    busy_m = busy16; done_m = done16; dz_m = dz16;
    q_m = {16'd0, q16}; r_m = {16'd0, r16};
    case (sel_w)
      8: begin
        busy_m = busy8; done_m = done8; dz_m = dz8;
        q_m = {24'd0, q8}; r_m = {24'd0, r8};
      end
      32: begin
        busy_m = busy32; done_m = done32; dz_m = dz32;
        q_m = q32; r_m = r32;
      end
      default: begin
        busy_m = busy16;
      end
    endcase
  end

  task automatic set_start(input int w, input logic v);
    st8  = (w == 8)  ? v : 1'b0;
    st16 = (w == 16) ? v : 1'b0;
    st32 = (w == 32) ? v : 1'b0;
  endtask

  // Called just after a falling edge; lat = rising edges after the accepting edge, -1 on timeout.
  task automatic run_op(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_seen);
    sel_w = w; sgn = s; a_v = a; b_v = b;
    set_start(w, 1'b1);
    lat = -1; busy_seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) begin
        set_start(w, 1'b0);
        busy_seen = busy_m;
      end
      if (done_m) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy8, done8, dz8, q8, r8} !== 19'd0) begin
      errors++; $display("FAIL reset_w8 got %h want 0", {busy8, done8, dz8, q8, r8});
    end
    checks++;
    if ({busy16, done16, dz16, q16, r16} !== 35'd0) begin
      errors++; $display("FAIL reset_w16 got %h want 0", {busy16, done16, dz16, q16, r16});
    end
    checks++;
    if ({busy32, done32, dz32, q32, r32} !== 67'd0) begin
      errors++; $display("FAIL reset_w32 got %h want 0", {busy32, done32, dz32, q32, r32});
    end
  endtask

  task automatic test_unsigned();
    int lat; logic bs;
    run_op(16, 1'b0, 32'd100, 32'd7, lat, bs);
    checks++;
    if (bs !== 1'b1) begin errors++; $display("FAIL uns_busy got %b want 1", bs); end
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL uns_latency got %0d want 17", lat); end
    checks++;
    if ({q_m, r_m, dz_m} !== {32'd14, 32'd2, 1'b0}) begin
      errors++; $display("FAIL uns_result got q=%h r=%h z=%b want q=e r=2 z=0", q_m, r_m, dz_m);
    end
  endtask

  task automatic test_signed();
    int lat; logic bs;
    run_op(16, 1'b1, 32'h0000_FFF9, 32'h0000_0002, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m, lat} !== {32'h0000_FFFD, 32'h0000_FFFF, 1'b0, 32'd17}) begin
      errors++; $display("FAIL sgn_neg_a got q=%h r=%h z=%b lat=%0d want q=fffd r=ffff z=0 lat=17", q_m, r_m, dz_m, lat);
    end
    run_op(16, 1'b1, 32'h0000_0007, 32'h0000_FFFE, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m} !== {32'h0000_FFFD, 32'h0000_0001, 1'b0}) begin
      errors++; $display("FAIL sgn_neg_b got q=%h r=%h z=%b want q=fffd r=1 z=0", q_m, r_m, dz_m);
    end
  endtask

  task automatic test_div_zero();
    int lat; logic bs;
    for (int m = 0; m < 2; m++) begin
      run_op(16, m[0], 32'h0000_1234, 32'd0, lat, bs);
      checks++;
      if ({bs, lat} !== {1'b1, 32'd1}) begin
        errors++; $display("FAIL dz_timing mode=%0d got busy=%b lat=%0d want busy=1 lat=1", m, bs, lat);
      end
      checks++;
      if ({q_m, r_m, dz_m} !== {32'h0000_FFFF, 32'h0000_1234, 1'b1}) begin
        errors++; $display("FAIL dz_result mode=%0d got q=%h r=%h z=%b want q=ffff r=1234 z=1", m, q_m, r_m, dz_m);
      end
    end
    run_op(16, 1'b0, 32'd100, 32'd7, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m} !== {32'd14, 32'd2, 1'b0}) begin
      errors++; $display("FAIL dz_clear got q=%h r=%h z=%b want q=e r=2 z=0", q_m, r_m, dz_m);
    end
  endtask

  task automatic test_overflow();
    int lat; logic bs;
    run_op(16, 1'b1, 32'h0000_8000, 32'h0000_FFFF, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m} !== {32'h0000_8000, 32'd0, 1'b0}) begin
      errors++; $display("FAIL min_by_m1 got q=%h r=%h z=%b want q=8000 r=0 z=0", q_m, r_m, dz_m);
    end
    run_op(16, 1'b0, 32'h0000_FFFF, 32'h0000_8001, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m} !== {32'd1, 32'h0000_7FFE, 1'b0}) begin
      errors++; $display("FAIL big_divisor got q=%h r=%h z=%b want q=1 r=7ffe z=0", q_m, r_m, dz_m);
    end
  endtask

  task automatic test_ignore_start();
    int lat; logic extra;
    sel_w = 16; sgn = 1'b0; a_v = 32'd100; b_v = 32'd7;
    set_start(16, 1'b1);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) set_start(16, 1'b0);
      if (i == 6) begin sgn = 1'b1; a_v = 32'd50; b_v = 32'd5; set_start(16, 1'b1); end
      if (i == 7) set_start(16, 1'b0);
      if (done_m) begin lat = i - 1; break; end
    end
    checks++;
    if ({q_m, r_m, dz_m, lat} !== {32'd14, 32'd2, 1'b0, 32'd17}) begin
      errors++; $display("FAIL ignore_start got q=%h r=%h z=%b lat=%0d want q=e r=2 z=0 lat=17", q_m, r_m, dz_m, lat);
    end
    extra = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_m || busy_m) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL ignore_no_side_op got %b want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int first_done, second_done;
    sel_w = 16; sgn = 1'b0; a_v = 32'd100; b_v = 32'd7;
    set_start(16, 1'b1);
    first_done = -1; second_done = -1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (i == 1) begin a_v = 32'd1000; b_v = 32'd10; end
      if (first_done > 0 && i == first_done + 1) set_start(16, 1'b0);
      if (done_m) begin
        if (first_done < 0) begin
          first_done = i;
          checks++;
          if ({q_m, r_m} !== {32'd14, 32'd2}) begin
            errors++; $display("FAIL b2b_first got q=%h r=%h want q=e r=2", q_m, r_m);
          end
        end else begin
          second_done = i;
          break;
        end
      end
    end
    set_start(16, 1'b0);
    checks++;
    if ((second_done - first_done) !== 18 || first_done < 0) begin
      errors++; $display("FAIL b2b_spacing got %0d want 18", second_done - first_done);
    end
    checks++;
    if ({q_m, r_m, dz_m} !== {32'd100, 32'd0, 1'b0}) begin
      errors++; $display("FAIL b2b_second got q=%h r=%h z=%b want q=64 r=0 z=0", q_m, r_m, dz_m);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic bs, saw;
    sel_w = 16; sgn = 1'b0; a_v = 32'd100; b_v = 32'd7;
    set_start(16, 1'b1);
    @(negedge clk);
    set_start(16, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy_m, done_m, dz_m, q_m, r_m} !== 67'd0) begin
      errors++; $display("FAIL rst_async got busy=%b done=%b q=%h r=%h want all 0", busy_m, done_m, q_m, r_m);
    end
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done_m) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL rst_no_done got %b want 0", saw); end
    run_op(16, 1'b0, 32'd9, 32'd3, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m, lat} !== {32'd3, 32'd0, 1'b0, 32'd17}) begin
      errors++; $display("FAIL rst_recover got q=%h r=%h z=%b lat=%0d want q=3 r=0 z=0 lat=17", q_m, r_m, dz_m, lat);
    end
  endtask

  task automatic test_widths();
    int lat; logic bs;
    run_op(8, 1'b0, 32'd100, 32'd7, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m, lat} !== {32'd14, 32'd2, 1'b0, 32'd9}) begin
      errors++; $display("FAIL w8_uns got q=%h r=%h z=%b lat=%0d want q=e r=2 z=0 lat=9", q_m, r_m, dz_m, lat);
    end
    run_op(8, 1'b1, 32'h80, 32'hFF, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m} !== {32'h80, 32'd0, 1'b0}) begin
      errors++; $display("FAIL w8_min got q=%h r=%h z=%b want q=80 r=0 z=0", q_m, r_m, dz_m);
    end
    run_op(8, 1'b0, 32'hFF, 32'h81, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m} !== {32'd1, 32'h7E, 1'b0}) begin
      errors++; $display("FAIL w8_big got q=%h r=%h z=%b want q=1 r=7e z=0", q_m, r_m, dz_m);
    end
    run_op(32, 1'b0, 32'd100, 32'd7, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m, lat} !== {32'd14, 32'd2, 1'b0, 32'd33}) begin
      errors++; $display("FAIL w32_uns got q=%h r=%h z=%b lat=%0d want q=e r=2 z=0 lat=33", q_m, r_m, dz_m, lat);
    end
    run_op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m} !== {32'h8000_0000, 32'd0, 1'b0}) begin
      errors++; $display("FAIL w32_min got q=%h r=%h z=%b want q=80000000 r=0 z=0", q_m, r_m, dz_m);
    end
    run_op(32, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, lat, bs);
    checks++;
    if ({q_m, r_m, dz_m} !== {32'd1, 32'h7FFF_FFFE, 1'b0}) begin
      errors++; $display("FAIL w32_big got q=%h r=%h z=%b want q=1 r=7ffffffe z=0", q_m, r_m, dz_m);
    end
  endtask

  initial begin
    rst = 1'b1; st8 = 1'b0; st16 = 1'b0; st32 = 1'b0; sgn = 1'b0;
    a_v = 32'd0; b_v = 32'd0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_widths();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
